// File: rtl/imem_scan_pkg.sv
// Shared types and field widths for the IMEM scan loader.
package imem_scan_pkg;

  // Header field widths and data word width, all shifted LSB first.
  localparam int unsigned OP_W   = 1;
  localparam int unsigned LEN_W  = 31;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [3:0] {
    StIdle,
    StOp,
    StLen,
    StAddr,
    StWdata,
    StRreq,
    StRwait,
    StRshift,
    StDone
  } scan_state_e;

endpackage

// File: rtl/scan_shift32.sv
// 32-bit right shift register with serial in/out, parallel load and a 5-bit bit counter.
// Serial data enters at the MSB, so after 32 shifts the first bit sits in bit 0.
module scan_shift32
  import imem_scan_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic              shift_en_i,
  input  logic              sin_i,
  output logic [WORD_W-1:0] shift_word_o,
  output logic              sout_o,
  output logic [4:0]        cnt_o,
  output logic              wrap_o
);

  logic [WORD_W-1:0] data_q, data_d;
  logic [4:0]        cnt_q, cnt_d;

  // Word as it will look once the current bit has been shifted in.
  assign shift_word_o = {sin_i, data_q[WORD_W-1:1]};
  assign sout_o       = data_q[0];
  assign cnt_o        = cnt_q;
  // Pulses on the 32nd shift of a word.
  assign wrap_o       = shift_en_i && !clr_i && !load_i && (cnt_q == 5'd31);

  // Next-state: clear beats load beats shift; load restarts the bit count.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      data_d = load_data_i;
      cnt_d  = '0;
    end else if (shift_en_i) begin
      data_d = shift_word_o;
      cnt_d  = cnt_q + 5'd1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_scan_loader.sv
// Serial scan loader/readback for the instruction memory.
// Frame: op bit, 31-bit word count, 32-bit start address, then 32-bit data words, all LSB
// first. The cycle on which scan_en first rises only moves IDLE to OP; the op bit is taken
// on the following cycle.
module imem_scan_loader
  import imem_scan_pkg::*;
#(
  parameter int unsigned IMEM_WORDS  = 4096,
  parameter int unsigned GNT_TIMEOUT = 31
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        scan_en_i,
  input  logic        scan_in_i,
  output logic        scan_out_o,
  output logic        core_hold_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_overrun_o,
  output logic        err_range_o
);

  localparam logic [63:0] ImemBytes = 64'(IMEM_WORDS) * 64'd4;
  localparam int unsigned TmoW      = (GNT_TIMEOUT < 2) ? 1 : $clog2(GNT_TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(GNT_TIMEOUT - 1);

  scan_state_e       state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [TmoW-1:0]   gnt_cnt_q, gnt_cnt_d;
  logic              err_ovr_q, err_ovr_d;
  logic              err_rng_q, err_rng_d;
  logic              req_timeout;

  logic              sh_clr, sh_load, sh_shift, sh_sout, sh_wrap;
  logic [WORD_W-1:0] sh_load_data, sh_word;
  logic [4:0]        sh_cnt;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return {32'd0, a} < ImemBytes;
  endfunction

  scan_shift32 u_shift (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (sh_clr),
    .load_i       (sh_load),
    .load_data_i  (sh_load_data),
    .shift_en_i   (sh_shift),
    .sin_i        (scan_in_i),
    .shift_word_o (sh_word),
    .sout_o       (sh_sout),
    .cnt_o        (sh_cnt),
    .wrap_o       (sh_wrap)
  );

  // Next-state: request handshake/timeout first, then the frame FSM may issue a new access.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    count_d      = count_q;
    addr_d       = addr_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    gnt_cnt_d    = gnt_cnt_q;
    err_ovr_d    = err_ovr_q;
    err_rng_d    = err_rng_q;
    req_timeout  = 1'b0;
    sh_clr       = 1'b0;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    sh_load_data = '0;

    // A new session starts with clean error flags.
    if (state_q == StIdle && scan_en_i) begin
      err_ovr_d = 1'b0;
      err_rng_d = 1'b0;
    end

    // Outstanding requests finish independently of the frame FSM, even across an abort.
    if (mem_req_q) begin
      if (mem_gnt_i) begin
        mem_req_d = 1'b0;
        gnt_cnt_d = '0;
      end else if (gnt_cnt_q == TmoLast) begin
        mem_req_d   = 1'b0;
        gnt_cnt_d   = '0;
        err_ovr_d   = 1'b1;
        req_timeout = 1'b1;
      end else begin
        gnt_cnt_d = gnt_cnt_q + TmoW'(1);
      end
    end

    if (!scan_en_i) begin
      state_d = StIdle;
      sh_clr  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StOp;
          sh_clr  = 1'b1;
        end
        StOp: begin
          op_d    = scan_in_i;
          state_d = StLen;
        end
        StLen: begin
          sh_shift = 1'b1;
          // 31st bit: the count occupies the upper 31 bits of the assembled word.
          if (sh_cnt == 5'd30) begin
            count_d = sh_word[WORD_W-1:1];
            sh_clr  = 1'b1;
            state_d = StAddr;
          end
        end
        StAddr: begin
          sh_shift = 1'b1;
          if (sh_wrap) begin
            addr_d = {sh_word[ADDR_W-1:2], 2'b00};
            if (count_q == '0) begin
              state_d = StDone;
            end else if (op_q[0]) begin
              state_d = StWdata;
            end else begin
              state_d = StRreq;
            end
          end
        end
        StWdata: begin
          sh_shift = 1'b1;
          if (sh_wrap) begin
            if (addr_in_range(addr_q)) begin
              // A previous write still waiting here loses its slot.
              if (mem_req_d) begin
                err_ovr_d = 1'b1;
              end
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_q;
              mem_wdata_d = sh_word;
              gnt_cnt_d   = '0;
            end else begin
              err_rng_d = 1'b1;
            end
            addr_d  = addr_q + 32'd4;
            count_d = count_q - LEN_W'(1);
            if (count_q == LEN_W'(1)) begin
              state_d = StDone;
            end
          end
        end
        StRreq: begin
          if (mem_req_q && !mem_we_q) begin
            if (mem_gnt_i) begin
              state_d = StRwait;
            end else if (req_timeout) begin
              // Keep the stream aligned: shift out zeros for the lost word.
              sh_load = 1'b1;
              state_d = StRshift;
            end
          end else if (!mem_req_q) begin
            if (addr_in_range(addr_q)) begin
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = addr_q;
              gnt_cnt_d  = '0;
            end else begin
              err_rng_d = 1'b1;
              sh_load   = 1'b1;
              state_d   = StRshift;
            end
          end
        end
        StRwait: begin
          if (mem_rvalid_i) begin
            sh_load      = 1'b1;
            sh_load_data = mem_rdata_i;
            state_d      = StRshift;
          end
        end
        StRshift: begin
          sh_shift = 1'b1;
          if (sh_wrap) begin
            addr_d  = addr_q + 32'd4;
            count_d = count_q - LEN_W'(1);
            state_d = (count_q == LEN_W'(1)) ? StDone : StRreq;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset; reset drops any in-flight request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      op_q        <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt_cnt_q   <= '0;
      err_ovr_q   <= 1'b0;
      err_rng_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_cnt_q   <= gnt_cnt_d;
      err_ovr_q   <= err_ovr_d;
      err_rng_q   <= err_rng_d;
    end
  end

  // Outputs are decoded from registers only.
  always_comb begin
    scan_out_o    = (state_q == StRshift) ? sh_sout : 1'b0;
    core_hold_o   = (state_q != StIdle) || mem_req_q;
    mem_req_o     = mem_req_q;
    mem_we_o      = mem_we_q;
    mem_addr_o    = mem_addr_q;
    mem_wdata_o   = mem_wdata_q;
    err_overrun_o = err_ovr_q;
    err_range_o   = err_rng_q;
  end

endmodule

// File: tb/tb_imem_scan_loader.sv
// Self-checking bench for imem_scan_loader: table of write sessions plus directed sequences
// for readback, overrun, abort and reset.
module tb_imem_scan_loader;
  import imem_scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, scan_en, scan_in;
  logic        scan_out, core_hold, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err_overrun, err_range;
  logic        gnt_en;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] rd_addr_log[$];
  int          req_cycles = 0;
  logic [31:0] imem [int];

  always #5 clk = ~clk;

  imem_scan_loader dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .scan_en_i     (scan_en),
    .scan_in_i     (scan_in),
    .scan_out_o    (scan_out),
    .core_hold_o   (core_hold),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .err_overrun_o (err_overrun),
    .err_range_o   (err_range)
  );

  // Memory responder: same-cycle grant when enabled, read data one cycle after grant.
  assign mem_gnt = mem_req && gnt_en;

  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (mem_req) req_cycles++;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        wr_addr_log.push_back(mem_addr);
        wr_data_log.push_back(mem_wdata);
      end else begin
        rd_addr_log.push_back(mem_addr);
        mem_rvalid <= 1'b1;
        mem_rdata  <= imem.exists(int'(mem_addr[31:2])) ? imem[int'(mem_addr[31:2])] : 32'h0;
      end
    end
  end

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] val, input int width);
    for (int i = 0; i < width; i++) begin
      scan_in = val[i];
      tick();
    end
  endtask

  task automatic write_header(input logic op, input logic [30:0] n, input logic [31:0] a);
    scan_en = 1'b1;
    scan_in = 1'b0;
    tick();
    send_bits({31'd0, op}, 1);
    send_bits({1'b0, n}, 31);
    send_bits(a, 32);
  endtask

  task automatic end_session();
    scan_en = 1'b0;
    scan_in = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [30:0] n;
    logic [31:0] a;
    int          nwords;
    int          exp_writes;
    logic        exp_rng;
    scan_state_e exp_state;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] words[8];

  initial begin
    int          wb, rb, nw;
    logic [31:0] base, rword;
    bit          seen;

    words[0] = 32'h00012117; words[1] = 32'hfe010113;
    words[2] = 32'h00112e23; words[3] = 32'h00812c23;
    words[4] = 32'h02010413; words[5] = 32'h00000513;
    words[6] = 32'h00a00593; words[7] = 32'h008000ef;

    vecs[0] = '{31'h7FFFFFFF, 32'h0,    8, 8, 1'b0, StWdata}; // long burst
    vecs[1] = '{31'd2,        32'h100,  3, 2, 1'b0, StDone};  // extra word ignored
    vecs[2] = '{31'd0,        32'h40,   1, 0, 1'b0, StDone};  // N=0, no access
    vecs[3] = '{31'd1,        32'h4000, 1, 0, 1'b1, StDone};  // first out-of-range address
    vecs[4] = '{31'd2,        32'h3FFC, 2, 1, 1'b1, StDone};  // last word then range error
    vecs[5] = '{31'd1,        32'h203,  1, 1, 1'b0, StDone};  // low address bits dropped

    imem[1]  = 32'hDEADBEEF;
    gnt_en   = 1'b1;
    scan_en  = 1'b0;
    scan_in  = 1'b0;
    rst_n    = 1'b0;
    repeat (3) tick();
    check("rst_ctrl", 0, {58'd0, scan_out, core_hold, mem_req, mem_we, err_overrun, err_range},
          64'd0);
    check("rst_addr", 0, {32'd0, mem_addr}, 64'd0);
    check("rst_wdata", 0, {32'd0, mem_wdata}, 64'd0);
    check("rst_state", 0, 64'(dut.state_q), 64'(StIdle));
    rst_n = 1'b1;
    tick();

    // Table of write sessions.
    for (int v = 0; v < 6; v++) begin
      wb = wr_addr_log.size();
      rb = req_cycles;
      write_header(1'b1, vecs[v].n, vecs[v].a);
      for (int w = 0; w < vecs[v].nwords; w++) send_bits(words[w], 32);
      repeat (2) tick();
      nw = wr_addr_log.size() - wb;
      check("vec_state", v, 64'(dut.state_q), 64'(vecs[v].exp_state));
      check("vec_nwrites", v, 64'(nw), 64'(vecs[v].exp_writes));
      check("vec_reqcyc", v, 64'(req_cycles - rb), 64'(vecs[v].exp_writes));
      check("vec_err_range", v, {63'd0, err_range}, {63'd0, vecs[v].exp_rng});
      check("vec_err_overrun", v, {63'd0, err_overrun}, 64'd0);
      base = vecs[v].a & 32'hFFFF_FFFC;
      for (int k = 0; k < vecs[v].exp_writes; k++) begin
        if (k < nw) begin
          check("vec_waddr", v * 10 + k, {32'd0, wr_addr_log[wb + k]}, {32'd0, base + 32'(4 * k)});
          check("vec_wdata", v * 10 + k, {32'd0, wr_data_log[wb + k]}, {32'd0, words[k]});
        end
      end
      end_session();
      check("vec_idle_hold", v, {63'd0, core_hold}, 64'd0);
    end

    // Readback of IMEM[1].
    rb = rd_addr_log.size();
    write_header(1'b0, 31'd1, 32'h4);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (mem_rvalid) seen = 1'b1;
      else tick();
    end
    check("rd_rvalid_seen", 0, {63'd0, seen}, 64'd1);
    check("rd_out_idle", 0, {63'd0, scan_out}, 64'd0);
    rword = '0;
    for (int i = 0; i < 32; i++) begin
      tick();
      rword[i] = scan_out;
    end
    check("rd_word", 0, {32'd0, rword}, 64'hDEADBEEF);
    check("rd_nreads", 0, 64'(rd_addr_log.size() - rb), 64'd1);
    if (rd_addr_log.size() > rb) check("rd_addr", 0, {32'd0, rd_addr_log[rb]}, 64'h4);
    tick();
    check("rd_state", 0, 64'(dut.state_q), 64'(StDone));
    check("rd_out_done", 0, {63'd0, scan_out}, 64'd0);
    end_session();

    // Grant withheld: write must be dropped with err_overrun.
    wb = wr_addr_log.size();
    gnt_en = 1'b0;
    write_header(1'b1, 31'd1, 32'h0);
    send_bits(32'h12345678, 32);
    repeat (20) tick();
    check("ovr_pending_req", 0, {63'd0, mem_req}, 64'd1);
    check("ovr_not_yet", 0, {63'd0, err_overrun}, 64'd0);
    repeat (20) tick();
    check("ovr_flag", 0, {63'd0, err_overrun}, 64'd1);
    check("ovr_req_dropped", 0, {63'd0, mem_req}, 64'd0);
    gnt_en = 1'b1;
    repeat (2) tick();
    check("ovr_nwrites", 0, 64'(wr_addr_log.size() - wb), 64'd0);
    end_session();

    // Abort at bit 17 of word 2; also confirms flags clear on a new session.
    wb = wr_addr_log.size();
    write_header(1'b1, 31'd4, 32'h80);
    check("abort_flags_clr", 0, {62'd0, err_overrun, err_range}, 64'd0);
    send_bits(32'hCAFEF00D, 32);
    send_bits(32'h0001FFFF, 17);
    end_session();
    check("abort_state", 0, 64'(dut.state_q), 64'(StIdle));
    check("abort_hold", 0, {63'd0, core_hold}, 64'd0);
    repeat (40) tick();
    check("abort_nwrites", 0, 64'(wr_addr_log.size() - wb), 64'd1);
    if (wr_addr_log.size() > wb) begin
      check("abort_waddr", 0, {32'd0, wr_addr_log[wb]}, 64'h80);
      check("abort_wdata", 0, {32'd0, wr_data_log[wb]}, 64'hCAFEF00D);
    end

    // Reset in WDATA with a write still waiting for grant.
    wb = wr_addr_log.size();
    gnt_en = 1'b0;
    write_header(1'b1, 31'd4, 32'h10);
    send_bits(32'hA5A50F0F, 32);
    send_bits(32'h3FF, 10);
    check("rst2_req_before", 0, {63'd0, mem_req}, 64'd1);
    rst_n = 1'b0;
    tick();
    check("rst2_ctrl", 0, {58'd0, scan_out, core_hold, mem_req, mem_we, err_overrun, err_range},
          64'd0);
    check("rst2_addr", 0, {32'd0, mem_addr}, 64'd0);
    check("rst2_wdata", 0, {32'd0, mem_wdata}, 64'd0);
    check("rst2_state", 0, 64'(dut.state_q), 64'(StIdle));
    scan_en = 1'b0;
    rst_n   = 1'b1;
    gnt_en  = 1'b1;
    repeat (5) tick();
    check("rst2_nwrites", 0, 64'(wr_addr_log.size() - wb), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_scan_loader.md
IMEM_SCAN_LOADER -- requirements
Module: imem_scan_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 4096, IMEM depth in 32-bit words.
REQ-002 Parameter GNT_TIMEOUT, default 31, maximum cycles allowed for mem_gnt after mem_req, before overrun.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 Rst_n  in  1  reset, synchronous and active-low.
REQ-005 scan_en  in  1  scan session active; sampled every clk.
REQ-006 scan_in  in  1  serial input, LSB first.
REQ-007 scan_out  out  1  serial readback output, LSB first.
REQ-008 core_hold  out  1  stalls the core while a session is active or a write is pending.
REQ-009 mem_req  out  1  IMEM access request.
REQ-010 mem_we  out  1  1 = write, 0 = read.
REQ-011 mem_addr  out  32  byte address, word aligned.
REQ-012 mem_wdata  out  32  write data.
REQ-013 mem_gnt  in  1  IMEM accepts the current request.
REQ-014 mem_rvalid  in  1  read data valid.
REQ-015 mem_rdata  in  32  read data.
REQ-016 err_overrun  out  1  sticky flag: write not granted within GNT_TIMEOUT cycles.
REQ-017 err_range  out  1  sticky flag: address at or beyond IMEM_WORDS*4.

Function
REQ-018 Frame format, every bit LSB first: 1 op bit (1 = write, 0 = read), 31-bit word count N, 32-bit start address A, then data.
REQ-019 FSM states and transitions:
- IDLE -> OP on the first cycle scan_en=1.
- OP -> LEN after 1 bit.
- LEN -> ADDR after 31 bits.
- ADDR -> WDATA or RREQ according to the op bit, after 32 bits.
REQ-020 WDATA: on the 32nd bit, the assembled word is copied to mem_wdata, mem_req=1, mem_we=1, mem_addr=current address, and shifting of the next word continues without gaps.
REQ-021 mem_req holds until the cycle mem_gnt=1, then deasserts on the next edge.
REQ-022 If mem_gnt has not arrived GNT_TIMEOUT cycles after mem_req, err_overrun is set and the pending word is dropped.
REQ-023 After each completed word: address += 4 (modulo 2^32), count -= 1.
REQ-024 When count reaches 0, the FSM goes to DONE; further scan_in bits are ignored.
REQ-025 N=0 goes directly from ADDR to DONE; no memory access occurs.
REQ-026 RREQ: issue mem_req with mem_we=0.
REQ-027 On mem_gnt, go to RWAIT.
REQ-028 On mem_rvalid, load the shift register with mem_rdata and go to RSHIFT.
REQ-029 RSHIFT drives scan_out = shift register bit 0 and shifts right once per cycle for 32 cycles, then goes to RREQ with the next address, or to DONE when count reaches 0.
REQ-030 scan_out = 0 in every state except RSHIFT.
REQ-031 An address >= IMEM_WORDS*4 sets err_range; that access is suppressed (no mem_req) but counting and shifting continue.
REQ-032 A word address is formed from mem_addr[31:2]; mem_addr[1:0] are always 0.
REQ-033 scan_en falling in any state returns the FSM to IDLE next cycle and discards any partial word or header.
REQ-034 A write already in mem_req when scan_en falls completes normally.
REQ-035 DONE -> IDLE when scan_en=0.
REQ-036 core_hold = 1 in any state except IDLE, and also while mem_req=1.
REQ-037 The error flags clear only on reset or on IDLE -> OP.

Reset
REQ-038 While Rst_n=0 at posedge clk:
- FSM = IDLE.
- mem_req, mem_we, scan_out, core_hold, err_overrun, err_range = 0.
- mem_addr, mem_wdata, count, bit counter and shift register = 0.
REQ-039 Reset mid-session aborts with no further memory access; any in-flight request is dropped.

Structure
REQ-040 Shared package imem_scan_pkg holds the FSM state enum, the header field widths (OP_W=1, LEN_W=31, ADDR_W=32) and WORD_W=32.
REQ-041 One sub-module, scan_shift32: a 32-bit shift register with serial in, serial out, parallel load and a 5-bit bit counter with a wrap pulse, used for header and data.

Verification
REQ-042 Write burst: header {1, 0x7FFFFFFF, 0x0}, then 8 words (0x00012117 ... 0x008000ef), mem_gnt same cycle.
- Required: 8 writes at addresses 0x0..0x1C with exact data.
- err_overrun stays 0.
REQ-043 Exact count: N=2, A=0x100, 3 words supplied.
- Required: writes at 0x100 and 0x104 only.
- FSM reaches DONE and the third word is ignored.
REQ-044 Readback: preload IMEM[1]=0xDEADBEEF; header {0, 1, 0x4}.
- Required: scan_out emits 0xDEADBEEF LSB first over 32 cycles after mem_rvalid.
REQ-045 Abort: deassert scan_en at bit 17 of word 2.
- Required: only word 1 written; FSM in IDLE next cycle; core_hold falls.
REQ-046 Faults:
- mem_gnt held low for 40 cycles sets err_overrun.
- A=IMEM_WORDS*4 sets err_range with no mem_req.
- Rst_n=0 mid-WDATA gives all outputs 0 on the next cycle.
